// File: rtl/cvp14_mem_ctrl.sv
// cvp14_mem_ctrl: single-port 16-bit word memory behind a FIFO write buffer.
// Reads complete one cycle after acceptance. Writes are buffered and retire
// into the array on any cycle that does not carry an accepted read. A small
// FSM tracks consecutive-address vector bursts.
// Optional feature: define CVP14_MEM_FWD_EN to serve reads from the write
// buffer (youngest matching entry). In the default build, a read stalls
// until the buffer has drained.
module cvp14_mem_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic        Clk1,
  input  logic        Reset_n,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic        V,
  input  logic [15:0] DataWr,
  output logic [15:0] DataRd,
  output logic        RdValid,
  output logic        Stall,
  output logic [4:0]  BurstCnt,
  output logic        Err
);

  localparam int PTR_W     = $clog2(WB_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_WORDS = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BURST_RD, BURST_WR} state_t;

  // Storage (no reset)
  logic [15:0]       r_mem     [MEM_WORDS];
  logic [ADDR_W-1:0] r_wb_addr [WB_DEPTH];
  logic [15:0]       r_wb_data [WB_DEPTH];

  // Control state
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_data;
  logic             r_valid;
  logic             r_err;
  state_t           r_state;
  logic [4:0]       r_burst_cnt;
  logic [15:0]      r_prev_addr;

  // Combinational
  logic              w_empty, w_full, w_oor;
  logic              w_accept, w_acc_rd, w_acc_wr;
  logic              w_push, w_retire;
  logic [ADDR_W-1:0] w_idx;
  logic [15:0]       w_rd_word;
  state_t            w_state_nxt;
  logic [4:0]        w_cnt_nxt;
  logic              w_burst_err, w_same_type, w_consec;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(WB_DEPTH));
  assign w_idx   = Addr[ADDR_W-1:0];
  assign w_oor   = (Addr >> ADDR_W) != 16'd0;

`ifdef CVP14_MEM_FWD_EN
  assign Stall = w_full;
`else
  // Holding reads off keeps the retire path running until the array is current.
  assign Stall = w_full | (RD & ~w_empty);
`endif

  assign w_accept = (RD ^ WR) & ~Stall;
  assign w_acc_rd = w_accept & RD;
  assign w_acc_wr = w_accept & WR;
  // Out-of-range writes are dropped and never reach the buffer.
  assign w_push   = w_acc_wr & ~w_oor;
  // The array port is free whenever no read is being served.
  assign w_retire = ~w_acc_rd & ~w_empty;

`ifdef CVP14_MEM_FWD_EN
  logic [PTR_W-1:0] w_slot;
  // Read word: array, overridden by the youngest live buffer entry at this address.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_rd_word = r_mem[w_idx];
    w_slot    = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_slot = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_wb_addr[w_slot] == w_idx)) begin
        w_rd_word = r_wb_data[w_slot];
      end
    end
  end
`else
  // Read word: buffer is always empty when a read is accepted.
  always_comb begin
    w_rd_word = r_mem[w_idx];
  end
`endif

  // Buffer and array storage writes.
  // NOTE: the array and buffer payload are deliberately left out of reset; only
  // the pointers/count define which entries are live.
  always_ff @(posedge Clk1) begin
    if (w_push) begin
      r_wb_addr[r_wr_ptr] <= w_idx;
      r_wb_data[r_wr_ptr] <= DataWr;
    end
    if (w_retire) begin
      r_mem[r_wb_addr[r_rd_ptr]] <= r_wb_data[r_rd_ptr];
    end
  end

  // Buffer pointers and occupancy; pointers wrap naturally modulo WB_DEPTH.
  always_ff @(posedge Clk1 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (w_push)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_retire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read response and error pulse; DataRd holds between valid pulses.
  always_ff @(posedge Clk1 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_acc_rd;
      r_err   <= (RD & WR) | (w_accept & w_oor) | w_burst_err;
      if (w_acc_rd) r_data <= w_oor ? 16'd0 : w_rd_word;
    end
  end

  assign w_same_type = (r_state == BURST_RD) ? RD : WR;
  assign w_consec    = (Addr == r_prev_addr + 16'd1);

  // Burst FSM next-state, counter and burst-error decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_burst_cnt;
    w_burst_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && V) begin
          w_state_nxt = RD ? BURST_RD : BURST_WR;
          w_cnt_nxt   = 5'd1;
        end
      end
      BURST_RD, BURST_WR: begin
        if (w_accept) begin
          if (!V) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 5'd0;
          end else if (!w_same_type || !w_consec || (r_burst_cnt == 5'd16)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 5'd0;
            w_burst_err = 1'b1;
          end else begin
            w_cnt_nxt = r_burst_cnt + 5'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  // Burst FSM state register; the last accepted address seeds the next consecutive check.
  always_ff @(posedge Clk1 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_burst_cnt <= 5'd0;
      r_prev_addr <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_cnt_nxt;
      if (w_accept) r_prev_addr <= Addr;
    end
  end

  assign DataRd   = r_data;
  assign RdValid  = r_valid;
  assign BurstCnt = r_burst_cnt;
  assign Err      = r_err;

endmodule
